keypad_entry: RTL and testbench
===============================

KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, inactivity limit in clk cycles (2..65535).
REQ-002 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port key_valid  input  1  one-cycle strobe: key_code holds a digit.
REQ-005 SHALL have port key_code  input  4  hex digit 0x0-0xF.
REQ-006 SHALL have port key_clr  input  1  one-cycle strobe: discard the partial entry.
REQ-007 SHALL have port key_ent  input  1  one-cycle strobe: submit the entry.
REQ-008 SHALL have port alarm  input  1  lockout indication from the downstream access checker.
REQ-009 SHALL have port password  output  12  assembled 3-digit password, first digit in [11:8].
REQ-010 SHALL have port enter  output  1  one-cycle submit pulse to the downstream checker.
REQ-011 SHALL have port digits  output  2  count of digits held, 0-3.
REQ-012 SHALL have port entry_err  output  1  one-cycle pulse on a rejected key.
REQ-013 SHALL have port timeout  output  1  one-cycle pulse when an idle partial entry is discarded.

Function
REQ-014 SHALL implement the states IDLE, COLLECT, FULL, SUBMIT and BLOCKED.
REQ-015 SHALL give simultaneous strobes the priority alarm > key_clr > key_ent > key_valid; lower-priority strobes in the same cycle are ignored with no entry_err.
REQ-016 SHALL, on an accepted digit, update password <= {password[7:0], key_code} and digits <= digits+1 in the next cycle: IDLE->COLLECT, COLLECT->FULL on the 3rd digit.
REQ-017 SHALL, on key_valid in FULL, keep password and digits unchanged and pulse entry_err (no wrap-around).
REQ-018 SHALL, on key_ent in FULL, go to SUBMIT for exactly one cycle with enter=1 and password stable; the cycle after that: IDLE, password=0, digits=0.
REQ-019 SHALL keep password constant from the cycle before enter rises until the cycle after enter falls.
REQ-020 SHALL, on key_ent in IDLE or COLLECT, pulse entry_err, clear password and digits, and go to IDLE with no enter.
REQ-021 SHALL, on key_clr in any state except BLOCKED, clear password and digits and go to IDLE the next cycle.
REQ-022 SHALL clear the inactivity counter in IDLE, on every accepted strobe, and on every strobe in FULL.
REQ-023 SHALL increment the inactivity counter each cycle otherwise, saturating at TIMEOUT_CYCLES-1.
REQ-024 SHALL, when the inactivity counter reaches TIMEOUT_CYCLES-1 in COLLECT or FULL, pulse timeout for one cycle, clear password and digits, and go to IDLE.
REQ-025 SHALL, whenever alarm=1 (including in SUBMIT), go to BLOCKED the next cycle with password=0 and digits=0.
REQ-026 SHALL, in BLOCKED, ignore all keys with no entry_err, and go to IDLE the cycle after alarm=0.
REQ-027 SHALL drive all outputs directly from registers.

Reset
REQ-028 SHALL, while rstn=0, immediately force state=IDLE, password=0, digits=0, enter=0, entry_err=0, timeout=0 and inactivity counter=0.
REQ-029 SHALL, on reset asserted mid-entry or during SUBMIT, produce no enter pulse and no partial password.
REQ-030 SHALL accept a key strobe on the first clk edge after rstn deasserts.

Structure
REQ-031 SHALL place the state encoding, DIGITS_MAX=3 and PW_WIDTH=12 in a shared package locker_pkg, for reuse by the access checker.
REQ-032 SHALL implement the inactivity counter as the sub-module idle_timer, with ports clk, rstn, clear, expired and parameter TIMEOUT_CYCLES; counter width = clog2(TIMEOUT_CYCLES).

Verification
REQ-033 SHALL cover: keys F,2,A then key_ent -> password=12'hF2A during the enter pulse, enter high exactly 1 cycle, then password=0 and digits=0.
REQ-034 SHALL cover: keys 0,A,A,9 then key_ent -> 4th key gives entry_err=1 and password stays 12'h0AA, then enter with 12'h0AA.
REQ-035 SHALL cover: keys E,C then key_ent -> entry_err=1, no enter, digits=0.
REQ-036 SHALL cover: TIMEOUT_CYCLES=8, key 9, then 7 idle cycles -> timeout pulse, digits=0, and a following E,C,E then key_ent gives enter with 12'hECE.
REQ-037 SHALL cover: key_clr and key_valid in the same cycle after 2 digits -> digits=0, digit discarded; alarm=1 during keying -> BLOCKED, keys ignored; alarm=0 -> IDLE.
REQ-038 SHALL cover: rstn pulsed low in SUBMIT -> enter drops immediately and all outputs are 0.

Source files
------------

// File: rtl/locker_pkg.sv
// Shared definitions for the keypad entry front end and the downstream access checker.
package locker_pkg;

  localparam int unsigned DIGITS_MAX = 3;
  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned PW_WIDTH   = DIGITS_MAX * DIGIT_W;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCollect = 3'd1,
    StFull    = 3'd2,
    StSubmit  = 3'd3,
    StBlocked = 3'd4
  } state_e;

endpackage

// File: rtl/idle_timer.sv
// Saturating inactivity counter; expired flags the cycle in which the count reaches its limit.
module idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != Limit) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Limit is never zero, so a cleared counter can never look expired.
  assign expired = (cnt_d == Limit);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end: collects three hex digits, submits them downstream, and handles
// clear, inactivity timeout and alarm lockout. Every output comes straight from a flop.
module keypad_entry
  import locker_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  input  logic                key_clr,
  input  logic                key_ent,
  input  logic                alarm,
  output logic [PW_WIDTH-1:0] password,
  output logic                enter,
  output logic [1:0]          digits,
  output logic                entry_err,
  output logic                timeout
);

  state_e              state_q, state_d;
  logic [PW_WIDTH-1:0] pw_q, pw_d;
  logic [1:0]          dig_q, dig_d;
  logic                enter_q, enter_d;
  logic                err_q, err_d;
  logic                to_q, to_d;
  logic                tmr_clear, tmr_expired;

  logic any_key, entering;
  assign any_key  = key_valid | key_clr | key_ent;
  assign entering = (state_q == StCollect) || (state_q == StFull);

  // Activity restarts the idle window; only COLLECT and FULL can time out.
  assign tmr_clear = (state_q == StIdle) || (entering && any_key);

  idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (tmr_clear),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d = state_q;
    pw_d    = pw_q;
    dig_d   = dig_q;
    enter_d = 1'b0;
    err_d   = 1'b0;
    to_d    = 1'b0;

    if (alarm) begin
      state_d = StBlocked;
      pw_d    = '0;
      dig_d   = '0;
    end else begin
      unique case (state_q)
        StBlocked: state_d = StIdle;
        StSubmit: begin
          state_d = StIdle;
          pw_d    = '0;
          dig_d   = '0;
        end
        StIdle, StCollect, StFull: begin
          if (key_clr) begin
            state_d = StIdle;
            pw_d    = '0;
            dig_d   = '0;
          end else if (key_ent) begin
            if (state_q == StFull) begin
              state_d = StSubmit;
              enter_d = 1'b1;
            end else begin
              state_d = StIdle;
              pw_d    = '0;
              dig_d   = '0;
              err_d   = 1'b1;
            end
          end else if (key_valid) begin
            if (state_q == StFull) begin
              err_d = 1'b1;
            end else begin
              pw_d    = {pw_q[PW_WIDTH-DIGIT_W-1:0], key_code};
              dig_d   = dig_q + 2'd1;
              state_d = (dig_q == 2'(DIGITS_MAX - 1)) ? StFull : StCollect;
            end
          end else if (entering && tmr_expired) begin
            state_d = StIdle;
            pw_d    = '0;
            dig_d   = '0;
            to_d    = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          pw_d    = '0;
          dig_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      pw_q    <= '0;
      dig_q   <= '0;
      enter_q <= 1'b0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pw_q    <= pw_d;
      dig_q   <= dig_d;
      enter_q <= enter_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign password  = pw_q;
  assign enter     = enter_q;
  assign digits    = dig_q;
  assign entry_err = err_q;
  assign timeout   = to_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Self-checking bench for keypad_entry: directed scenarios plus randomized traffic
// compared against a digit-queue reference model.
module tb_keypad_entry;

  localparam int unsigned T = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        key_clr = 1'b0;
  logic        key_ent = 1'b0;
  logic        alarm = 1'b0;
  logic [11:0] password;
  logic        enter;
  logic [1:0]  digits;
  logic        entry_err;
  logic        timeout;

  int n_checks = 0;
  int n_fail   = 0;

  keypad_entry #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_clr  (key_clr),
    .key_ent  (key_ent),
    .alarm    (alarm),
    .password (password),
    .enter    (enter),
    .digits   (digits),
    .entry_err(entry_err),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: digits held as a queue, plus lockout / submit flags and
  // a count of quiet cycles since the last activity.
  int   mq[$];
  bit   m_blk, m_sub;
  int   m_idle;
  logic exp_enter, exp_err, exp_to;

  function automatic logic [11:0] model_pw();
    int acc = 0;
    foreach (mq[i]) acc = acc * 16 + mq[i];
    return 12'(acc);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_blk = 0; m_sub = 0; m_idle = 0;
    exp_enter = 0; exp_err = 0; exp_to = 0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] c, input logic clr,
                            input logic ent, input logic al);
    bit strobe   = v | clr | ent;
    bit idle_ph  = !m_blk && !m_sub && mq.size() == 0;
    bit active   = !m_blk && !m_sub && mq.size() > 0;
    exp_enter = 0; exp_err = 0; exp_to = 0;
    if (idle_ph || (active && strobe)) m_idle = 0;
    else if (m_idle < int'(T) - 1) m_idle++;
    if (al) begin
      m_blk = 1; m_sub = 0; mq.delete();
    end else if (m_blk) begin
      m_blk = 0;
    end else if (m_sub) begin
      m_sub = 0; mq.delete();
    end else if (clr) begin
      mq.delete();
    end else if (ent) begin
      if (mq.size() == 3) begin
        m_sub = 1; exp_enter = 1;
      end else begin
        exp_err = 1; mq.delete();
      end
    end else if (v) begin
      if (mq.size() == 3) exp_err = 1;
      else mq.push_back(int'(c));
    end else if (active && m_idle == int'(T) - 1) begin
      exp_to = 1; mq.delete();
    end
  endtask

  task automatic tick(input logic v, input logic [3:0] c, input logic clr,
                      input logic ent, input logic al);
    key_valid = v; key_code = c; key_clr = clr; key_ent = ent; alarm = al;
    @(posedge clk);
    model_step(v, c, clr, ent, al);
    #1;
    key_valid = 0; key_clr = 0; key_ent = 0; alarm = 0;
  endtask

  task automatic key(input logic [3:0] c);
    tick(1'b1, c, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    tick(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    model_reset();
    #23;
    n_checks++;
    if (password !== 12'h000) begin n_fail++; $display("FAIL reset_pw got=%h exp=000", password); end
    n_checks++;
    if (digits !== 2'd0) begin n_fail++; $display("FAIL reset_digits got=%0d exp=0", digits); end
    n_checks++;
    if ({enter, entry_err, timeout} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses got=%b exp=000", {enter, entry_err, timeout});
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_submit();
    key(4'hF); key(4'h2); key(4'hA);
    n_checks++;
    if (digits !== 2'd3 || password !== 12'hF2A) begin
      n_fail++; $display("FAIL full_f2a got=%h/%0d exp=f2a/3", password, digits);
    end
    tick(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (enter !== 1'b1 || password !== 12'hF2A) begin
      n_fail++; $display("FAIL enter_f2a got=%b/%h exp=1/f2a", enter, password);
    end
    idle();
    n_checks++;
    if (enter !== 1'b0 || password !== 12'h000 || digits !== 2'd0) begin
      n_fail++; $display("FAIL after_submit got=%b/%h/%0d exp=0/000/0", enter, password, digits);
    end
  endtask

  task automatic test_overflow();
    key(4'h0); key(4'hA); key(4'hA); key(4'h9);
    n_checks++;
    if (entry_err !== 1'b1 || password !== 12'h0AA || digits !== 2'd3) begin
      n_fail++; $display("FAIL overflow got=%b/%h/%0d exp=1/0aa/3", entry_err, password, digits);
    end
    tick(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (enter !== 1'b1 || password !== 12'h0AA || entry_err !== 1'b0) begin
      n_fail++; $display("FAIL enter_0aa got=%b/%h/%b exp=1/0aa/0", enter, password, entry_err);
    end
    idle();
  endtask

  task automatic test_short_enter();
    key(4'hE); key(4'hC);
    tick(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (entry_err !== 1'b1 || enter !== 1'b0 || digits !== 2'd0 || password !== 12'h000) begin
      n_fail++;
      $display("FAIL short_enter got=%b/%b/%0d/%h exp=1/0/0/000", entry_err, enter, digits, password);
    end
    idle();
  endtask

  task automatic test_timeout();
    int n = 0;
    key(4'h9);
    do begin
      idle();
      n++;
    end while (timeout !== 1'b1 && n < 20);
    n_checks++;
    if (n != int'(T) - 1) begin n_fail++; $display("FAIL timeout_cycles got=%0d exp=%0d", n, T - 1); end
    n_checks++;
    if (digits !== 2'd0 || password !== 12'h000) begin
      n_fail++; $display("FAIL timeout_clear got=%h/%0d exp=000/0", password, digits);
    end
    idle();
    n_checks++;
    if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse got=%b exp=0", timeout); end
    key(4'hE); key(4'hC); key(4'hE);
    tick(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (enter !== 1'b1 || password !== 12'hECE) begin
      n_fail++; $display("FAIL enter_ece got=%b/%h exp=1/ece", enter, password);
    end
    idle();
  endtask

  task automatic test_clr_alarm();
    key(4'h1); key(4'h2);
    tick(1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (digits !== 2'd0 || password !== 12'h000 || entry_err !== 1'b0) begin
      n_fail++; $display("FAIL clr_prio got=%h/%0d/%b exp=000/0/0", password, digits, entry_err);
    end
    key(4'h3);
    tick(1'b1, 4'h4, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 4'(i + 6), 1'b0, (i == 1), 1'b1);
      n_checks++;
      if (digits !== 2'd0 || password !== 12'h000 || entry_err !== 1'b0 || enter !== 1'b0) begin
        n_fail++; $display("FAIL blocked_%0d got=%h/%0d/%b exp=000/0/0", i, password, digits, entry_err);
      end
    end
    tick(1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (digits !== 2'd0 || entry_err !== 1'b0) begin
      n_fail++; $display("FAIL unblock_ignore got=%0d/%b exp=0/0", digits, entry_err);
    end
    key(4'h4);
    n_checks++;
    if (digits !== 2'd1 || password !== 12'h004) begin
      n_fail++; $display("FAIL after_unblock got=%h/%0d exp=004/1", password, digits);
    end
    tick(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_submit();
    key(4'h1); key(4'h2); key(4'h3);
    tick(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (enter !== 1'b1) begin n_fail++; $display("FAIL pre_reset_enter got=%b exp=1", enter); end
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if ({enter, entry_err, timeout, digits, password} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_in_submit got=%b/%0d/%h exp=000/0/000", {enter, entry_err, timeout},
               digits, password);
    end
    @(negedge clk);
    rstn = 1'b1;
    key(4'h5);
    n_checks++;
    if (digits !== 2'd1 || password !== 12'h005) begin
      n_fail++; $display("FAIL first_key_after_reset got=%h/%0d exp=005/1", password, digits);
    end
    tick(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic v, clr, ent, al;
    logic [3:0] c;
    for (int i = 0; i < 500; i++) begin
      if ((i % 60) >= 48) begin
        v = 0; clr = 0; ent = 0; al = 0;
      end else begin
        v   = 1'($urandom_range(0, 1));
        clr = ($urandom_range(0, 14) == 0);
        ent = ($urandom_range(0, 4) == 0);
        al  = ($urandom_range(0, 39) == 0);
      end
      c = 4'($urandom_range(0, 15));
      tick(v, c, clr, ent, al);
      n_checks++;
      if (password !== model_pw()) begin
        n_fail++; $display("FAIL rnd_pw[%0d] got=%h exp=%h", i, password, model_pw());
      end
      n_checks++;
      if (digits !== 2'(mq.size())) begin
        n_fail++; $display("FAIL rnd_digits[%0d] got=%0d exp=%0d", i, digits, mq.size());
      end
      n_checks++;
      if (enter !== exp_enter) begin
        n_fail++; $display("FAIL rnd_enter[%0d] got=%b exp=%b", i, enter, exp_enter);
      end
      n_checks++;
      if (entry_err !== exp_err) begin
        n_fail++; $display("FAIL rnd_err[%0d] got=%b exp=%b", i, entry_err, exp_err);
      end
      n_checks++;
      if (timeout !== exp_to) begin
        n_fail++; $display("FAIL rnd_timeout[%0d] got=%b exp=%b", i, timeout, exp_to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_submit();
    test_overflow();
    test_short_enter();
    test_timeout();
    test_clr_alarm();
    test_reset_submit();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
